// File: rtl/game_sprite_pkg.sv
// Shared types and helpers for the sprite bounce driver: FSM states,
// screen-edge limit arithmetic and two's-complement speed helpers.
package game_sprite_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_MOVE,
    S_HOLD,
    S_DONE
  } state_e;

  localparam int unsigned DEF_XMAX = 640 - 8;
  localparam int unsigned DEF_YMAX = 480 - 8;

  // Largest top-left coordinate that keeps the sprite fully on screen.
  function automatic int unsigned edge_max(input int unsigned screen, input int unsigned sprite);
    return screen - sprite;
  endfunction

  function automatic logic [31:0] spd_neg(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic spd_is_neg(input logic [31:0] v, input int unsigned w);
    return v[w-1];
  endfunction

endpackage

// File: rtl/game_sprite_edge_detect.sv
// Combinational screen-edge detector: flags which edges the sprite has reached
// given its travel direction, and the position clamped onto the hit edge.
module game_sprite_edge_detect
  import game_sprite_pkg::*;
#(
  parameter int          X_WIDTH  = 10,
  parameter int          Y_WIDTH  = 10,
  parameter int          DX_WIDTH = 2,
  parameter int          DY_WIDTH = 2,
  parameter int unsigned XMAX     = DEF_XMAX,
  parameter int unsigned YMAX     = DEF_YMAX
) (
  input  logic [X_WIDTH-1:0]  x,
  input  logic [Y_WIDTH-1:0]  y,
  input  logic [DX_WIDTH-1:0] dx,
  input  logic [DY_WIDTH-1:0] dy,
  output logic                hit_left,
  output logic                hit_right,
  output logic                hit_top,
  output logic                hit_bottom,
  output logic [X_WIDTH-1:0]  clamp_x,
  output logic [Y_WIDTH-1:0]  clamp_y
);

  localparam logic [X_WIDTH-1:0] XMAX_C = X_WIDTH'(XMAX);
  localparam logic [Y_WIDTH-1:0] YMAX_C = Y_WIDTH'(YMAX);

  logic dx_neg, dx_pos, dy_neg, dy_pos;

  always_comb begin
    dx_neg = spd_is_neg(32'(dx), DX_WIDTH);
    dy_neg = spd_is_neg(32'(dy), DY_WIDTH);
    dx_pos = !dx_neg && (dx != '0);
    dy_pos = !dy_neg && (dy != '0);
    // Moving left past 0 wraps to a large value, so x > XMAX also means "left".
    hit_left   = dx_neg && ((x == '0) || (x > XMAX_C));
    hit_right  = dx_pos && (x >= XMAX_C);
    hit_top    = dy_neg && ((y == '0) || (y > YMAX_C));
    hit_bottom = dy_pos && (y >= YMAX_C);
    clamp_x = hit_left ? '0 : (hit_right  ? XMAX_C : x);
    clamp_y = hit_top  ? '0 : (hit_bottom ? YMAX_C : y);
  end

endmodule

// File: rtl/game_sprite_bounce_driver.sv
// Launches a sprite, reflects its velocity at screen edges and freezes it on
// stop or after a bounce limit; drives the sprite's write port.
module game_sprite_bounce_driver
  import game_sprite_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int SPRITE_WIDTH  = 8,
  parameter int SPRITE_HEIGHT = 8,
  parameter int X_WIDTH       = 10,
  parameter int Y_WIDTH       = 10,
  parameter int DX_WIDTH      = 2,
  parameter int DY_WIDTH      = 2,
  parameter int COUNT_WIDTH   = 8,
  parameter int MAX_BOUNCES   = 0,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [X_WIDTH-1:0]     launch_x,
  input  logic [Y_WIDTH-1:0]     launch_y,
  input  logic [DX_WIDTH-1:0]    launch_dx,
  input  logic [DY_WIDTH-1:0]    launch_dy,
  input  logic [X_WIDTH-1:0]     sprite_x,
  input  logic [Y_WIDTH-1:0]     sprite_y,
  output logic                   sprite_write,
  output logic [X_WIDTH-1:0]     sprite_write_x,
  output logic [Y_WIDTH-1:0]     sprite_write_y,
  output logic [DX_WIDTH-1:0]    sprite_write_dx,
  output logic [DY_WIDTH-1:0]    sprite_write_dy,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] bounce_count
);

  localparam int unsigned XMAX = edge_max(SCREEN_WIDTH, SPRITE_WIDTH);
  localparam int unsigned YMAX = edge_max(SCREEN_HEIGHT, SPRITE_HEIGHT);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] BOUNCE_LIMIT = COUNT_WIDTH'(MAX_BOUNCES);

  state_e state_q, state_d;
  logic [DX_WIDTH-1:0]    dx_q, dx_d;
  logic [DY_WIDTH-1:0]    dy_q, dy_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   wr_q, wr_d;
  logic [X_WIDTH-1:0]     wx_q, wx_d, clamp_x;
  logic [Y_WIDTH-1:0]     wy_q, wy_d, clamp_y;
  logic hit_left, hit_right, hit_top, hit_bottom, hit_x, hit_y;
  logic do_launch, do_freeze, do_reflect, do_count;

  game_sprite_edge_detect #(
    .X_WIDTH (X_WIDTH),
    .Y_WIDTH (Y_WIDTH),
    .DX_WIDTH(DX_WIDTH),
    .DY_WIDTH(DY_WIDTH),
    .XMAX    (XMAX),
    .YMAX    (YMAX)
  ) u_edge (
    .x         (sprite_x),
    .y         (sprite_y),
    .dx        (dx_q),
    .dy        (dy_q),
    .hit_left  (hit_left),
    .hit_right (hit_right),
    .hit_top   (hit_top),
    .hit_bottom(hit_bottom),
    .clamp_x   (clamp_x),
    .clamp_y   (clamp_y)
  );

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    do_launch  = 1'b0;
    do_freeze  = 1'b0;
    do_reflect = 1'b0;
    do_count   = 1'b0;
    hit_x      = hit_left | hit_right;
    hit_y      = hit_top | hit_bottom;
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // A write may never follow a write, so start/stop wait out a strobe cycle.
    case (state_q)
      S_IDLE, S_DONE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start && !wr_q) begin
          do_launch = 1'b1;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_HOLD;
        hold_d  = '0;
      end
      S_HOLD: begin
        if (stop && !wr_q) begin
          do_freeze = 1'b1;
          state_d   = S_IDLE;
        end else if (hold_q == HOLD_LAST) begin
          state_d = S_MOVE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_MOVE: begin
        if (stop) begin
          do_freeze = 1'b1;
          state_d   = S_IDLE;
        end else if (hit_x || hit_y) begin
          do_count = 1'b1;
          if ((MAX_BOUNCES != 0) && (cnt_inc == BOUNCE_LIMIT)) begin
            do_freeze = 1'b1;
            state_d   = S_DONE;
          end else begin
            do_reflect = 1'b1;
            state_d    = S_HOLD;
            hold_d     = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_d  = do_launch | do_freeze | do_reflect;
    wx_d  = wx_q;
    wy_d  = wy_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    cnt_d = do_count ? cnt_inc : cnt_q;
    if (do_launch) begin
      wx_d  = launch_x;
      wy_d  = launch_y;
      dx_d  = launch_dx;
      dy_d  = launch_dy;
      cnt_d = '0;
    end else if (do_freeze) begin
      wx_d = sprite_x;
      wy_d = sprite_y;
      dx_d = '0;
      dy_d = '0;
    end else if (do_reflect) begin
      wx_d = clamp_x;
      wy_d = clamp_y;
      if (hit_x) dx_d = DX_WIDTH'(spd_neg(32'(dx_q)));
      if (hit_y) dy_d = DY_WIDTH'(spd_neg(32'(dy_q)));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      dx_q    <= '0;
      dy_q    <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      wr_q    <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
    end else begin
      state_q <= state_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      wr_q    <= wr_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
    end
  end

  // The tracked speed is by construction the last written speed.
  assign sprite_write    = wr_q;
  assign sprite_write_x  = wx_q;
  assign sprite_write_y  = wy_q;
  assign sprite_write_dx = dx_q;
  assign sprite_write_dy = dy_q;
  assign busy            = (state_q == S_LAUNCH) || (state_q == S_MOVE) || (state_q == S_HOLD);
  assign done            = (state_q == S_DONE);
  assign bounce_count    = cnt_q;

endmodule

// File: tb/tb_game_sprite_bounce_driver.sv
// Scoreboard bench: stimulus pushes the expected sprite writes computed from
// the bounce rules; a negedge monitor pops and compares every write strobe.
module tb_game_sprite_bounce_driver;

  localparam int XMAX = 632;
  localparam int YMAX = 472;
  localparam int MAXB = 3;
  localparam int SAFE_X = 320;
  localparam int SAFE_Y = 240;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] dx;
    logic [1:0] dy;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [9:0] launch_x, launch_y, sprite_x, sprite_y;
  logic [1:0] launch_dx, launch_dy;
  logic       sprite_write, busy, done;
  logic [9:0] sprite_write_x, sprite_write_y;
  logic [1:0] sprite_write_dx, sprite_write_dy;
  logic [7:0] bounce_count;

  game_sprite_bounce_driver #(.MAX_BOUNCES(MAXB)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .launch_x       (launch_x),
    .launch_y       (launch_y),
    .launch_dx      (launch_dx),
    .launch_dy      (launch_dy),
    .sprite_x       (sprite_x),
    .sprite_y       (sprite_y),
    .sprite_write   (sprite_write),
    .sprite_write_x (sprite_write_x),
    .sprite_write_y (sprite_write_y),
    .sprite_write_dx(sprite_write_dx),
    .sprite_write_dy(sprite_write_dy),
    .busy           (busy),
    .done           (done),
    .bounce_count   (bounce_count)
  );

  always #5 clk = ~clk;

  wr_t sb[$];
  int  total = 0;
  int  bad = 0;
  int  mdx, mdy, mcnt;
  bit  mbusy = 0;
  bit  mdone = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic wr_t mk(input int x, input int y, input int dx, input int dy);
    wr_t w;
    w.x  = 10'(x);
    w.y  = 10'(y);
    w.dx = 2'(dx);
    w.dy = 2'(dy);
    return w;
  endfunction

  // Monitor: every strobe must match the oldest expectation.
  wr_t got, want;
  bit  prev_wr = 0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_wr = 0;
    end else begin
      if (sprite_write) begin
        check("no_back_to_back_write", prev_wr, 0);
        check("write_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          want = sb.pop_front();
          got  = {sprite_write_x, sprite_write_y, sprite_write_dx, sprite_write_dy};
          check("write_data", got, want);
        end
      end
      prev_wr = sprite_write;
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("write_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_status(input string tag);
    check({tag, "_busy"}, busy, mbusy);
    check({tag, "_done"}, done, mdone);
    check({tag, "_count"}, bounce_count, mcnt);
  endtask

  task automatic launch(input int x, input int y, input int dx, input int dy);
    repeat (2) @(negedge clk);
    launch_x = 10'(x); launch_y = 10'(y); launch_dx = 2'(dx); launch_dy = 2'(dy);
    start = 1'b1;
    sb.push_back(mk(x, y, dx, dy));
    mdx = dx; mdy = dy; mcnt = 0; mbusy = 1; mdone = 0;
    @(negedge clk);
    start = 1'b0;
    check("launch_busy", busy, 1);
    check("launch_count", bounce_count, 0);
    wait_drain();
  endtask

  // Present a position; the model decides from the edge rules whether a write follows.
  task automatic do_bounce(input int x, input int y);
    bit lft, rgt, top, bot, hx, hy;
    int nx, ny, ndx, ndy;
    lft = (mdx >= 2) && (x == 0 || x > XMAX);
    rgt = (mdx == 1) && (x >= XMAX);
    top = (mdy >= 2) && (y == 0 || y > YMAX);
    bot = (mdy == 1) && (y >= YMAX);
    hx = lft || rgt;
    hy = top || bot;
    @(negedge clk);
    sprite_x = 10'(x);
    sprite_y = 10'(y);
    if (hx || hy) begin
      mcnt++;
      if (mcnt == MAXB) begin
        sb.push_back(mk(x, y, 0, 0));
        mdx = 0; mdy = 0; mbusy = 0; mdone = 1;
      end else begin
        nx  = lft ? 0 : (rgt ? XMAX : x);
        ny  = top ? 0 : (bot ? YMAX : y);
        ndx = hx ? (4 - mdx) % 4 : mdx;
        ndy = hy ? (4 - mdy) % 4 : mdy;
        sb.push_back(mk(nx, ny, ndx, ndy));
        mdx = ndx; mdy = ndy;
      end
      wait_drain();
    end else begin
      repeat (6) @(negedge clk);
    end
    sprite_x = 10'(SAFE_X);
    sprite_y = 10'(SAFE_Y);
    check_status("bounce");
  endtask

  task automatic do_stop(input int x, input int y);
    repeat (3) @(negedge clk);
    sprite_x = 10'(x);
    sprite_y = 10'(y);
    stop = 1'b1;
    sb.push_back(mk(x, y, 0, 0));
    mdx = 0; mdy = 0; mbusy = 0; mdone = 0;
    wait_drain();
    @(negedge clk);
    stop = 1'b0;
    sprite_x = 10'(SAFE_X);
    sprite_y = 10'(SAFE_Y);
    check_status("stop");
  endtask

  function automatic int rand_coord(input int maxv);
    case ($urandom_range(0, 4))
      0:       return 0;
      1:       return maxv;
      2:       return int'($urandom_range(maxv + 1, 1023));
      default: return int'($urandom_range(1, maxv - 1));
    endcase
  endfunction

  initial begin
    launch_x = '0; launch_y = '0; launch_dx = '0; launch_dy = '0;
    sprite_x = 10'(SAFE_X);
    sprite_y = 10'(SAFE_Y);
    repeat (3) @(negedge clk);
    check("rst_write", sprite_write, 0);
    check("rst_wx", sprite_write_x, 0);
    check("rst_wy", sprite_write_y, 0);
    check("rst_wdx", sprite_write_dx, 0);
    check("rst_wdy", sprite_write_dy, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", bounce_count, 0);
    reset = 1'b1;

    launch(100, 100, 1, 1);
    do_bounce(632, 100);            // right edge
    do_bounce(0, 472);              // corner: left + bottom in one write
    do_bounce(632, 300);            // third bounce freezes, done
    launch(200, 200, 3, 1);         // relaunch from DONE
    do_bounce(1023, 200);           // left wrap
    do_stop(632, 472);              // stop beats a pending edge

    for (int i = 0; i < 60; i++) begin
      if (!mbusy)
        launch(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else if ($urandom_range(0, 9) == 0)
        do_stop(rand_coord(XMAX), rand_coord(YMAX));
      else
        do_bounce(rand_coord(XMAX), rand_coord(YMAX));
    end

    // Reset during HOLD: outputs clear and no strobe appears.
    if (mbusy) do_stop(SAFE_X, SAFE_Y);
    repeat (2) @(negedge clk);
    launch_x = 10'd50; launch_y = 10'd60; launch_dx = 2'd1; launch_dy = 2'd3;
    start = 1'b1;
    sb.push_back(mk(50, 60, 1, 3));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("midrst_write", sprite_write, 0);
    check("midrst_wx", sprite_write_x, 0);
    check("midrst_wdx", sprite_write_dx, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", bounce_count, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("in_reset_no_write", sprite_write, 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_no_write", sprite_write, 0);
      check("post_reset_idle", busy, 0);
    end
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
